// File: rtl/bp_mac_seq_pkg.sv
// bp_mac_seq_pkg: shared gate encodings, weight-set bit position and sequencer states.
package bp_mac_seq_pkg;
    localparam logic [1:0] GATE_A = 2'd0;
    localparam logic [1:0] GATE_I = 2'd1;
    localparam logic [1:0] GATE_F = 2'd2;
    localparam logic [1:0] GATE_O = 2'd3;
    localparam int SELW_U = 2;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;
endpackage

// File: rtl/bp_mac_seq_ctrl_delay.sv
// ctrl_delay: fixed-depth shift register with asynchronous active-low clear.
module ctrl_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH == 0) begin : g_pass
        assign q = d;
    end else begin : g_sr
        logic [WIDTH-1:0] sr [DEPTH];
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
            end else begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        assign q = sr[DEPTH-1];
    end
endmodule

// File: rtl/bp_mac_seq.sv
// bp_mac_seq: backprop MAC lane sequencer issuing gate/cell/output terms and result writes.
module bp_mac_seq
    import bp_mac_seq_pkg::*;
#(
    parameter int N_OUT    = 8,
    parameter int N_CELL   = 8,
    parameter int DG_ADDR  = 6,
    parameter int W_ADDR   = 9,
    parameter int OUT_ADDR = 4,
    parameter int RD_LAT   = 1,
    parameter int MAC_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sel_u,
    output logic                busy,
    output logic                done,
    output logic [DG_ADDR-1:0]  rd_addr_dg,
    output logic [W_ADDR-1:0]   rd_addr_w,
    output logic [1:0]          sel_dgate,
    output logic [2:0]          sel_wghts,
    output logic                acc_mac,
    output logic                wr_res,
    output logic [OUT_ADDR-1:0] wr_addr_res
);
    localparam int DRAIN = RD_LAT + MAC_LAT;
    localparam int DW = $clog2(DRAIN + 2);
    localparam int VW = 5 + OUT_ADDR;
    localparam int WW = 1 + OUT_ADDR;

    state_t state, state_nx;
    logic [1:0] g;
    logic [DG_ADDR-1:0] k;
    logic [OUT_ADDR-1:0] j;
    logic [W_ADDR-1:0] w;
    logic [DW-1:0] dcnt;
    logic su, issue, g_last, k_last, j_last, t_last;
    logic [VW-1:0] iv, dv;
    logic [WW-1:0] wi, wo;
    logic v1, a1, l1;
    logic [1:0] g1;
    logic [OUT_ADDR-1:0] j1;

    assign issue  = state == S_ISSUE;
    assign g_last = g == GATE_O;
    assign k_last = k == DG_ADDR'(N_CELL - 1);
    assign j_last = j == OUT_ADDR'(N_OUT - 1);
    assign t_last = issue && g_last && k_last && j_last;

    always_comb begin
        state_nx = state;
        if (state == S_IDLE && start) state_nx = S_ISSUE;
        if (t_last) state_nx = DRAIN == 0 ? S_FIN : S_DRAIN;
        if (state == S_DRAIN && dcnt == DW'(DRAIN - 1)) state_nx = S_FIN;
        if (state == S_FIN) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= S_IDLE;
            g     <= '0;
            k     <= '0;
            j     <= '0;
            w     <= '0;
            su    <= 1'b0;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            dcnt  <= state == S_DRAIN ? dcnt + 1'b1 : '0;
            if (state == S_IDLE && start) begin
                su <= sel_u;
                g  <= '0;
                k  <= '0;
                j  <= '0;
                w  <= '0;
            end else if (issue) begin
                g <= g + 1'b1;
                w <= w + 1'b1;
                if (g_last) k <= k_last ? '0 : k + 1'b1;
                if (g_last && k_last) j <= j + 1'b1;
            end
        end

    // Issue-stage control word; zero outside ISSUE so delayed copies idle at 0.
    assign iv = issue ? {1'b1, g, !(g == GATE_A && k == '0), j, g_last && k_last} : '0;

    ctrl_delay #(.WIDTH(VW), .DEPTH(RD_LAT)) u_rd_dly (
        .clk (clk),
        .rst (rst),
        .d   (iv),
        .q   (dv)
    );

    assign {v1, g1, a1, j1, l1} = dv;
    assign wi = v1 && l1 ? {1'b1, j1} : '0;

    ctrl_delay #(.WIDTH(WW), .DEPTH(MAC_LAT)) u_mac_dly (
        .clk (clk),
        .rst (rst),
        .d   (wi),
        .q   (wo)
    );

    assign busy        = state != S_IDLE;
    assign done        = state == S_FIN;
    assign rd_addr_dg  = issue ? k : '0;
    assign rd_addr_w   = issue ? w : '0;
    assign sel_dgate   = g1;
    assign sel_wghts   = v1 ? {su, g1} : '0;
    assign acc_mac     = a1;
    assign {wr_res, wr_addr_res} = wo;
endmodule
